// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug memory access engine.
//   - ocimem_state_e : engine state encoding
//   - JDO_*          : bit offsets of the fields carried in the 38-bit jdo word
//   - DBG_TMO_DATA   : value loaded into MonDReg when an access is aborted
package nios2_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } ocimem_state_e;

  localparam int JDO_W            = 38;
  localparam int JDO_ADDR_LSB     = 26;  // address occupies [ADDR_W+25:26]
  localparam int JDO_RD_AFTER_SET = 25;
  localparam int JDO_CLR_ERR      = 24;
  localparam int JDO_WDATA_LSB    = 3;
  localparam int JDO_WDATA_MSB    = 34;
  localparam int JDO_RD_NEXT      = 35;

  localparam logic [31:0] DBG_TMO_DATA = 32'hDEADDEAD;

endpackage

// File: rtl/nios2_dbg_ocimem_engine.sv
// Sysclk-domain debug memory access engine.
//
// Turns the debug slave's take_* strobes plus the jdo word into single-word
// Avalon-MM reads/writes on the debug RAM and reports the outcome back in
// MonDReg / monitor_ready / monitor_error.
//
// Ports
//   clk, reset_n                 : clock, asynchronous active-low reset
//   jdo[37:0]                    : command/data word from the debug slave
//   take_action_ocimem_a         : set address (optionally read)
//   take_action_ocimem_b         : write jdo data at the current address
//   take_no_action_ocimem_a      : read next word (when jdo[35]=1)
//   MonDReg, monitor_ready,
//   monitor_error                : status back to the TCK stage
//   avm_*                        : Avalon-MM master to the debug RAM
//
// Handshake: avm_read / avm_write are held with a stable address and data
// while avm_waitrequest is high; the request is accepted in the first cycle
// it is high with avm_waitrequest low. Read data returns later on
// avm_readdatavalid, which is only honoured while waiting for it.
module nios2_dbg_ocimem_engine
  import nios2_dbg_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mon_q, mon_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic sel_b, sel_a, sel_n;
  logic op_done;
  logic tmo_fire;

  // jdo bits that no field maps onto.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mon_d    = mon_q;
    tmo_d    = tmo_q;
    ready_d  = ready_q;
    error_d  = error_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    op_done  = 1'b0;
    tmo_fire = 1'b0;

    // One strobe per cycle is acted on: b over a over no_action_a.
    sel_b = take_action_ocimem_b;
    sel_a = take_action_ocimem_a & ~take_action_ocimem_b;
    sel_n = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_b) begin
          mon_d   = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          wr_d    = 1'b1;
          state_d = ST_WR_REQ;
          ready_d = 1'b0;
          tmo_d   = '0;
        end else if (sel_a) begin
          addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
          if (jdo[JDO_RD_AFTER_SET]) begin
            rd_d    = 1'b1;
            state_d = ST_RD_REQ;
            ready_d = 1'b0;
            tmo_d   = '0;
          end
        end else if (sel_n && jdo[JDO_RD_NEXT]) begin
          rd_d    = 1'b1;
          state_d = ST_RD_REQ;
          ready_d = 1'b0;
          tmo_d   = '0;
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          rd_d    = 1'b0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (avm_readdatavalid) begin
          op_done = 1'b1;
          mon_d   = avm_readdata;
          addr_d  = addr_q + 1'b1;
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (!avm_waitrequest) begin
          op_done = 1'b1;
          wr_d    = 1'b0;
          addr_d  = addr_q + 1'b1;
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + 8'd1;
      // Busy: every strobe is an overrun and its command is dropped.
      if (sel_b || sel_a || sel_n) error_d = 1'b1;
      // A request accepted in the last allowed cycle still has to wait for
      // data, so only a finishing operation beats the timeout.
      if (tmo_q == TMO_LAST && !op_done) tmo_fire = 1'b1;
    end

    // The error-clear of ocimem_a is honoured even when its command is not.
    if (sel_a && jdo[JDO_CLR_ERR]) error_d = 1'b0;

    if (tmo_fire) begin
      state_d = ST_IDLE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      mon_d   = DBG_TMO_DATA;
      addr_d  = addr_q;
      ready_d = 1'b1;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      tmo_q   <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = mon_q;

endmodule
